// File: rtl/booth8_mant_mul_seq.sv
// Sequential radix-8 Booth mantissa multiplier: one Booth digit per cycle through an external PP selector.
// Optional BOOTH_EARLY_EXIT_EN: finish as soon as every remaining multiplier digit is zero.
module booth8_mant_mul_seq #(
  parameter int MW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MW-1:0]   in_a,
  input  logic [MW-1:0]   in_b,
  output logic [3:0]      pp_sel,
  output logic            pp_neg,
  output logic [MW-1:0]   pp_y,
  output logic [MW+1:0]   pp_y3,
  input  logic [MW+1:0]   pp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*MW-1:0] out_prod
);
  localparam int NG = (MW + 3) / 3;
  localparam int AW = 2 * MW + 4;
  localparam int BW = MW + 4;
  localparam int IW = $clog2(NG + 1);

  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;
  state_t state, state_nxt;

  logic [MW-1:0] a_reg;
  logic [BW-1:0] b_reg;
  logic [MW+1:0] y3_reg;
  logic [AW-1:0] acc;
  logic [IW-1:0] idx;
  logic [BW-1:0] b_win;
  logic [3:0]    g;
  logic [2:0]    s;
  logic [2:0]    mag;
  logic          last_digit;
  logic [AW-1:0] addend;

  // Digit value is -4*g3 + s; when g3 is set the magnitude is 4 - s.
  always_comb begin
    b_win  = b_reg >> (3 * int'(idx));
    g      = b_win[3:0];
    s      = {1'b0, g[2], 1'b0} + {2'b00, g[1]} + {2'b00, g[0]};
    mag    = g[3] ? (3'd4 - s) : s;
    pp_neg = (state == ITER) && g[3] && (s != 3'd4);
    pp_sel = 4'b0000;
    if (state == ITER) begin
      case (mag)
        3'd1:    pp_sel = 4'b0001;
        3'd2:    pp_sel = 4'b0010;
        3'd3:    pp_sel = 4'b0100;
        3'd4:    pp_sel = 4'b1000;
        default: pp_sel = 4'b0000;
      endcase
    end
  end

  // Selector returns the one's complement for negative digits; the +1 completes the negation.
  assign addend = {{(AW-MW-2){pp_neg}}, pp} + {{(AW-1){1'b0}}, pp_neg};

`ifdef BOOTH_EARLY_EXIT_EN
  logic [BW-1:0] b_rest;
  always_comb begin
    b_rest     = b_reg >> (3 * int'(idx) + 3);
    last_digit = (int'(idx) == NG - 1) || (b_rest == '0);
  end
`else
  assign last_digit = (int'(idx) == NG - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = PRE;
      end
      PRE:  state_nxt = ITER;
      ITER: if (last_digit) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      y3_reg <= '0;
      acc    <= '0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= in_a;
          b_reg <= {3'b000, in_b, 1'b0};
          acc   <= '0;
          idx   <= '0;
        end
        PRE:  y3_reg <= {2'b00, a_reg} + {1'b0, a_reg, 1'b0};
        ITER: begin
          acc <= acc + (addend << (3 * int'(idx)));
          idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // An unsigned product never reaches the guard bits.
  always_ff @(posedge clk) begin
    if (!rst && state == DONE) assert (acc[AW-1:2*MW] == '0);
  end

  assign pp_y     = a_reg;
  assign pp_y3    = y3_reg;
  assign out_prod = acc[2*MW-1:0];

endmodule

// File: tb/tb_booth8_mant_mul_seq.sv
// Bench for booth8_mant_mul_seq: plain-arithmetic product/latency model, directed corners, random stalls.
module tb_booth8_mant_mul_seq;
  localparam int MW   = 24;
  localparam int NG   = (MW + 3) / 3;
  localparam int NOPS = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [23:0]   in_a, in_b;
  logic [3:0]    pp_sel;
  logic          pp_neg;
  logic [23:0]   pp_y;
  logic [25:0]   pp_y3;
  logic [25:0]   pp;
  logic          out_valid;
  logic          out_ready;
  logic [47:0]   out_prod;

  booth8_mant_mul_seq #(.MW(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .pp_sel(pp_sel), .pp_neg(pp_neg),
    .pp_y(pp_y), .pp_y3(pp_y3), .pp(pp), .out_valid(out_valid),
    .out_ready(out_ready), .out_prod(out_prod)
  );

  always #5 clk = ~clk;

  // External partial-product selector.
  logic [25:0] sel_mag;
  always_comb begin
    sel_mag = '0;
    case (pp_sel)
      4'b0001: sel_mag = {2'b00, pp_y};
      4'b0010: sel_mag = {1'b0, pp_y, 1'b0};
      4'b0100: sel_mag = pp_y3;
      4'b1000: sel_mag = {pp_y, 2'b00};
      default: sel_mag = '0;
    endcase
    pp = sel_mag ^ {26{pp_neg}};
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_push = 0;
  int n_done = 0;
  bit seen_valid = 0;

  typedef struct {
    logic [47:0] prod;
    int          due;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired t=%0t", name, $time);
  endtask

  // Cycles from the accept edge (counted as 1) to the edge that raises out_valid.
  function automatic int lat(input logic [23:0] b);
`ifdef BOOTH_EARLY_EXIT_EN
    for (int i = 0; i < NG; i++)
      if ((b >> (3 * i + 2)) == 24'd0) return 3 + i;
    return 2 + NG;
`else
    return 2 + NG;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      n_push = n_push - q.size();
      q.delete();
      seen_valid = 0;
    end else begin
      chk("in_ready_vs_busy", 64'(in_ready), 64'(q.size() == 0));
      if (out_valid) begin
        if (q.size() == 0) begin
          tmo("spurious_out_valid");
        end else begin
          chk("out_prod", 64'(out_prod), 64'(q[0].prod));
          if (!seen_valid) begin
            chk("latency_cycle", 64'(cyc), 64'(q[0].due));
            seen_valid = 1;
          end
          if (out_ready) begin
            void'(q.pop_front());
            seen_valid = 0;
            n_done++;
          end
        end
      end else if (q.size() != 0 && !seen_valid && cyc == q[0].due) begin
        chk("out_valid_due", 64'(out_valid), 64'd1);
      end
      if (in_valid && in_ready) begin
        q.push_back('{prod: 48'(in_a) * 48'(in_b), due: cyc + lat(in_b)});
        n_push++;
      end
    end
  end

  task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                        input logic [47:0] lit, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) tmo("idle_wait");
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) begin
      tmo("op_done_wait");
      out_ready = 1'b1;
      return;
    end
    chk("literal_prod", 64'(out_prod), 64'(lit));
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        in_valid = (k == 2);
        in_a = 24'h5A5A5A;
        in_b = 24'h0F0F0F;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  function automatic logic [23:0] rand_op();
    logic [23:0] r;
    r = 24'($urandom);
    case ($urandom_range(0, 7))
      0: r = 24'd0;
      1: r = 24'($urandom_range(0, 3));
      2: r = 24'hFFFFFF;
      3: r = r >> $urandom_range(0, 23);
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int guard;
    int push0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_prod", 64'(out_prod), 64'd0);
    chk("rst_pp_sel", 64'(pp_sel), 64'd0);
    chk("rst_pp_neg", 64'(pp_neg), 64'd0);
    chk("rst_pp_y", 64'(pp_y), 64'd0);
    chk("rst_pp_y3", 64'(pp_y3), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Abort an operation partway through the digit walk.
    in_valid = 1'b1; in_a = 24'h123456; in_b = 24'hFEDCBA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    chk("postrst_out_valid", 64'(out_valid), 64'd0);

    run_op(24'h000123, 24'h000456, 48'h00000004EDC2, 0);
    run_op(24'h800000, 24'h800000, 48'h400000000000, 0);
    run_op(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 0);
    run_op(24'hABCDEF, 24'h000000, 48'h000000000000, 0);
    run_op(24'hABCDEF, 24'h000003, 48'h0000020369CD, 5);
    run_op(24'h000001, 24'h000007, 48'h000000000007, 0);
    run_op(24'h000000, 24'hFFFFFF, 48'h000000000000, 0);

    push0 = n_push;
    guard = 0;
    while ((n_push - push0) < NOPS && guard < 60000) begin
      @(posedge clk); #1;
      guard++;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = rand_op();
      in_b      = rand_op();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    if (guard >= 60000) tmo("random_phase");
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (q.size() != 0) tmo("drain");
    chk("ops_completed", 64'(n_done), 64'(n_push));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
